// File: rtl/modulation_bus_if.sv
// rtl/modulation_bus_if.sv - modulation table lookup bus between reader and responder
interface modulation_bus_if;
    logic [14:0] IDX;
    logic        SEGMENT;
    logic [7:0]  VALUE;

    modport responder (input IDX, input SEGMENT, output VALUE);
    modport reader    (output IDX, output SEGMENT, input VALUE);
endinterface

// File: rtl/modulation_memory.sv
// rtl/modulation_memory.sv - dual-segment modulation table, CPU word writes, 2-cycle pipelined lookup
module modulation_memory #(
    parameter int         DEPTH      = 32768,
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CPU_WE,
    input  logic                      CPU_SEGMENT,
    input  logic [13:0]               CPU_ADDR,
    input  logic [15:0]               CPU_DATA,
    modulation_bus_if.responder       MOD_BUS,
    output logic                      BUSY,
    output logic                      WR_DROPPED
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          WORDS    = DEPTH / 2;
    localparam int          WAW      = (AW > 1) ? AW - 1 : 1;
    localparam logic [31:0] WORDS_U  = 32'(WORDS);
    localparam logic [14:0] IDX_MASK = 15'(DEPTH - 1);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WAW-1:0] init_cnt;
    logic           init_last;
    logic           init_we;

    assign init_last = (init_cnt == WAW'(WORDS - 1));
    assign BUSY      = (state == S_INIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT)
                init_cnt <= init_cnt + WAW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_last) state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_INIT;
        endcase
    end

    // CPU writes are registered first and committed one edge later
    logic           addr_ok;
    logic           wr_en;
    logic           wr_seg;
    logic [WAW-1:0] wr_addr;
    logic [15:0]    wr_data;

    assign addr_ok = ({18'd0, CPU_ADDR} < WORDS_U);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en      <= 1'b0;
            WR_DROPPED <= 1'b0;
        end else begin
            wr_en <= CPU_WE && !BUSY && addr_ok;
            if (CPU_WE && (BUSY || !addr_ok))
                WR_DROPPED <= 1'b1;
        end
        wr_seg  <= CPU_SEGMENT;
        wr_addr <= WAW'(CPU_ADDR);
        wr_data <= CPU_DATA;
    end

    logic           mem_we0;
    logic           mem_we1;
    logic [WAW-1:0] mem_addr;
    logic [15:0]    mem_wdata;

    assign init_we = BUSY && !RST;

    // Init sequencer owns the write port of both arrays while busy
    always_comb begin
        mem_we0   = 1'b0;
        mem_we1   = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (init_we) begin
            mem_we0   = 1'b1;
            mem_we1   = 1'b1;
            mem_addr  = init_cnt;
            mem_wdata = {INIT_VALUE, INIT_VALUE};
        end else if (wr_en) begin
            mem_we0 = !wr_seg;
            mem_we1 = wr_seg;
        end
    end

    logic [15:0]    mem0 [WORDS];
    logic [15:0]    mem1 [WORDS];
    logic [WAW-1:0] rd_word;
    logic [15:0]    rdata0;
    logic [15:0]    rdata1;

    always_ff @(posedge CLK) begin
        if (mem_we0)
            mem0[mem_addr] <= mem_wdata;
        rdata0 <= mem0[rd_word];
    end

    always_ff @(posedge CLK) begin
        if (mem_we1)
            mem1[mem_addr] <= mem_wdata;
        rdata1 <= mem1[rd_word];
    end

    logic        rd_byte1;
    logic        rd_byte2;
    logic        rd_seg1;
    logic        rd_seg2;
    logic        rd_busy1;
    logic        rd_busy2;
    logic [15:0] rd_sel;

    assign rd_sel = rd_seg2 ? rdata1 : rdata0;

    // Busy flag travels with the request so masking keeps the same latency
    always_ff @(posedge CLK) begin
        rd_word  <= WAW'((MOD_BUS.IDX & IDX_MASK) >> 1);
        rd_byte1 <= MOD_BUS.IDX[0];
        rd_seg1  <= MOD_BUS.SEGMENT;
        rd_byte2 <= rd_byte1;
        rd_seg2  <= rd_seg1;
        if (RST) begin
            rd_busy1      <= 1'b1;
            rd_busy2      <= 1'b1;
            MOD_BUS.VALUE <= INIT_VALUE;
        end else begin
            rd_busy1      <= BUSY;
            rd_busy2      <= rd_busy1;
            MOD_BUS.VALUE <= rd_busy2 ? INIT_VALUE : (rd_byte2 ? rd_sel[15:8] : rd_sel[7:0]);
        end
    end

endmodule

// File: tb/tb_modulation_memory.sv
// tb/tb_modulation_memory.sv - scoreboard bench for modulation_memory with DEPTH=16
module tb_modulation_memory;

    localparam int         DEPTH = 16;
    localparam logic [7:0] INIT  = 8'h00;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CPU_WE = 1'b0;
    logic        CPU_SEGMENT = 1'b0;
    logic [13:0] CPU_ADDR = '0;
    logic [15:0] CPU_DATA = '0;
    logic        BUSY;
    logic        WR_DROPPED;

    modulation_bus_if mod_bus ();

    modulation_memory #(.DEPTH(DEPTH), .INIT_VALUE(INIT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CPU_WE      (CPU_WE),
        .CPU_SEGMENT (CPU_SEGMENT),
        .CPU_ADDR    (CPU_ADDR),
        .CPU_DATA    (CPU_DATA),
        .MOD_BUS     (mod_bus),
        .BUSY        (BUSY),
        .WR_DROPPED  (WR_DROPPED)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string      tag;
        logic [7:0] exp;
        int         due;
    } sb_t;

    sb_t        sb [$];
    logic [7:0] mdl [2][DEPTH];
    int         rst_edge = -100;
    logic       drop_mdl = 1'b0;
    int         checks   = 0;
    int         failures = 0;
    int         busy_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock step: retire due reads, check flags, drive new stimulus, advance model
    task automatic step(input logic rst, input logic we, input logic wseg, input logic [13:0] waddr,
                        input logic [15:0] wdata, input logic rd, input logic rseg,
                        input logic [14:0] idx, input string tag);
        int  n;
        sb_t e;
        @(negedge CLK);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_eq(e.tag, {24'd0, mod_bus.VALUE}, {24'd0, e.exp});
        end
        if (rst_edge >= 0) begin
            check_eq("busy", {31'd0, BUSY}, {31'd0, (cyc >= rst_edge && cyc <= rst_edge + 7)});
            check_eq("wr_dropped", {31'd0, WR_DROPPED}, {31'd0, drop_mdl});
        end
        RST             = rst;
        CPU_WE          = we;
        CPU_SEGMENT     = wseg;
        CPU_ADDR        = waddr;
        CPU_DATA        = wdata;
        mod_bus.IDX     = idx;
        mod_bus.SEGMENT = rseg;
        n = cyc + 1;
        if (rst) begin
            rst_edge = n;
            drop_mdl = 1'b0;
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < DEPTH; i++)
                    mdl[s][i] = INIT;
        end
        if (rd) begin
            e.tag = tag;
            e.exp = (n <= rst_edge + 8) ? INIT : mdl[rseg][int'(idx) % DEPTH];
            e.due = n + 2;
            sb.push_back(e);
        end
        if (we && !rst) begin
            if (n <= rst_edge + 8 || int'(waddr) >= DEPTH / 2) begin
                drop_mdl = 1'b1;
            end else begin
                mdl[wseg][2 * int'(waddr)]     = wdata[7:0];
                mdl[wseg][2 * int'(waddr) + 1] = wdata[15:8];
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 14'd0, 16'd0, 1'b0, 1'b0, 15'd0, "idle");
    endtask

    task automatic rd(input logic seg, input logic [14:0] idx, input string tag);
        step(1'b0, 1'b0, 1'b0, 14'd0, 16'd0, 1'b1, seg, idx, tag);
    endtask

    task automatic wr(input logic seg, input logic [13:0] addr, input logic [15:0] data);
        step(1'b0, 1'b1, seg, addr, data, 1'b0, 1'b0, 15'd0, "wr");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 14'd0, 16'd0, 1'b0, 1'b0, 15'd0, "rst");
        for (int i = 0; i < 12; i++) begin
            rd(1'(i), 15'($urandom_range(0, 31)), "init_rd");
            if (BUSY === 1'b1) busy_cnt++;
        end
        check_eq("busy_cycles", busy_cnt, 8);

        wr(1'b0, 14'd3, 16'hBEEF);
        idle();
        rd(1'b0, 15'd6, "t2_lo");
        rd(1'b0, 15'd7, "t2_hi");

        wr(1'b1, 14'd3, 16'h1234);
        idle();
        rd(1'b0, 15'd6, "t3_s0_lo");
        rd(1'b1, 15'd6, "t3_s1_lo");
        rd(1'b0, 15'd7, "t3_s0_hi");
        rd(1'b1, 15'd7, "t3_s1_hi");

        step(1'b0, 1'b1, 1'b0, 14'd0, 16'h00AA, 1'b1, 1'b0, 15'd0, "t4_collide");
        rd(1'b0, 15'd0, "t4_new");
        rd(1'b0, 15'd1, "t4_hi");

        rd(1'b0, 15'd22, "t5_wrap");
        wr(1'b0, 14'd8, 16'hFFFF);
        idle();
        rd(1'b0, 15'd16, "t5_after_drop");
        rd(1'b0, 15'h7FF7, "t5_wrap_hi");
        wr(1'b1, 14'd5, 16'h1122);
        wr(1'b1, 14'd5, 16'h3344);
        rd(1'b1, 15'd10, "b2b_lo");
        rd(1'b1, 15'd11, "b2b_hi");

        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 7)),
                 16'($urandom), 1'b1, 1'($urandom_range(0, 1)), 15'($urandom), "rand");
        idle();
        idle();
        idle();

        step(1'b1, 1'b0, 1'b0, 14'd0, 16'd0, 1'b0, 1'b0, 15'd0, "rst2");
        for (int i = 0; i < 10; i++)
            step(1'b0, (i == 4), 1'b0, 14'd1, 16'h5A5A, 1'b1, 1'(i), 15'($urandom_range(0, 15)), "t6_busy_rd");
        rd(1'b0, 15'd6, "t6_s0_6");
        rd(1'b1, 15'd6, "t6_s1_6");
        rd(1'b0, 15'd0, "t6_s0_0");
        rd(1'b1, 15'd11, "t6_s1_11");
        idle();
        idle();
        idle();

        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
